// File: rtl/seq_gen_pkg.sv
// ---------------------------------------------------------------------------
// seq_gen_pkg
//
// Shared definitions for the seq_gen instruction sequencer:
//   - 4-bit opcode type and the opcode constants SEQ_GEN_NO .. SEQ_GEN_RT
//   - run/halt state type for the sticky error state
//   - helper functions that locate the operand fields (cmd, chan, addr)
//     from the configured widths, so every user agrees on the bit layout
// ---------------------------------------------------------------------------
package seq_gen_pkg;

  typedef logic [3:0] seq_gen_op_t;

  localparam seq_gen_op_t SEQ_GEN_NO = 4'd0;  // no operation
  localparam seq_gen_op_t SEQ_GEN_CI = 4'd1;  // command, immediate data
  localparam seq_gen_op_t SEQ_GEN_CR = 4'd2;  // command, input-register data
  localparam seq_gen_op_t SEQ_GEN_JI = 4'd3;  // jump to immediate address
  localparam seq_gen_op_t SEQ_GEN_JR = 4'd4;  // jump to input-register value
  localparam seq_gen_op_t SEQ_GEN_JZ = 4'd5;  // jump if register is zero
  localparam seq_gen_op_t SEQ_GEN_JN = 4'd6;  // jump if register is non-zero
  localparam seq_gen_op_t SEQ_GEN_CA = 4'd7;  // call (push return address)
  localparam seq_gen_op_t SEQ_GEN_RT = 4'd8;  // return (pop address)

  // Once a fault is taken the sequencer parks in HALT until reset.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } seq_gen_state_e;

  // LSB of the cmd field: it sits directly above the immediate.
  function automatic int seq_gen_cmd_lsb(input int data_width);
    return data_width;
  endfunction

  // LSB of the chan field: it sits directly above cmd.
  function automatic int seq_gen_chan_lsb(input int data_width, input int cmd_width);
    return data_width + cmd_width;
  endfunction

  // LSB of the addr field: it is left-aligned in the operand.
  function automatic int seq_gen_addr_lsb(input int op_width, input int addr_width);
    return op_width - addr_width;
  endfunction

endpackage

// File: rtl/seq_gen_stack.sv
// ---------------------------------------------------------------------------
// seq_gen_stack
//
// Return-address LIFO for seq_gen. Only instantiated when the
// SEQ_GEN_STACK_EN macro is defined.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   synchronous active-high reset; empties the stack
//   push       in   write push_data on top (ignored when full)
//   pop        in   discard the top entry (ignored when empty)
//   push_data  in   Width-bit value to push
//   top        out  current top entry (valid when !empty)
//   full       out  Depth entries held
//   empty      out  no entries held
// ---------------------------------------------------------------------------
module seq_gen_stack #(
  parameter int Depth = 4,
  parameter int Width = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] push_data,
  output logic [Width-1:0] top,
  output logic             full,
  output logic             empty
);

  // count ranges 0..Depth; the storage index only needs to reach Depth-1.
  localparam int CntW = $clog2(Depth + 1);
  localparam int IdxW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem [2**IdxW];
  logic [CntW-1:0]  count;
  logic [CntW-1:0]  count_m1;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CntW'(Depth));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign count_m1 = count - CntW'(1);
  assign top      = mem[count_m1[IdxW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (do_push) begin
      count <= count + CntW'(1);
    end else if (do_pop) begin
      count <= count_m1;
    end
  end

  // NOTE: the storage array has no reset; clearing count is enough to make
  // every entry unreachable, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[count[IdxW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/seq_gen.sv
// ---------------------------------------------------------------------------
// seq_gen
//
// Parametrised instruction sequencer. Executes one instruction per clock
// with inst_en=1: either issues a {cmd,data} word with a one-hot channel
// strobe, or updates the program counter `next`. Faults (illegal opcode,
// out-of-range register/channel, stack overflow/underflow) set a sticky
// `error` and suppress the faulting instruction; only reset clears it.
//
// Configuration macro: SEQ_GEN_STACK_EN
//   defined     : CA/RT are legal, a StackDepth-entry return stack is built
//   not defined : CA/RT are illegal opcodes, no stack storage exists
//
// Ports:
//   clock     in   rising-edge clock
//   reset     in   synchronous active-high reset (wins over inst_en)
//   inst      in   {opcode[3:0], operand[OpWidth-1:0]}
//   inst_en   in   instruction valid this cycle
//   ireg      in   NumIRegs input registers, DataWidth bits each
//   next      out  program counter (instruction memory address)
//   oreg      out  last issued command word {cmd, data}
//   oreg_wen  out  one-hot channel strobe, one cycle per CI/CR
//   error     out  sticky fault flag
// ---------------------------------------------------------------------------
module seq_gen
  import seq_gen_pkg::*;
#(
  parameter int DataWidth  = 8,
  parameter int AddrWidth  = 8,
  parameter int CmdWidth   = 4,
  parameter int NumIRegs   = 4,
  parameter int NumOChans  = 8,
  parameter int OpWidth    = 16,
  parameter int StackDepth = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [OpWidth+3:0]            inst,
  input  logic                          inst_en,
  input  logic [NumIRegs*DataWidth-1:0] ireg,
  output logic [AddrWidth-1:0]          next,
  output logic [CmdWidth+DataWidth-1:0] oreg,
  output logic [NumOChans-1:0]          oreg_wen,
  output logic                          error
);

  localparam int IRegW   = $clog2(NumIRegs);
  localparam int OChanW  = $clog2(NumOChans);
  localparam int CmdLsb  = seq_gen_cmd_lsb(DataWidth);
  localparam int ChanLsb = seq_gen_chan_lsb(DataWidth, CmdWidth);
  localparam int AddrLsb = seq_gen_addr_lsb(OpWidth, AddrWidth);

  // Compared at 32 bits so the range checks stay meaningful when the
  // register/channel counts are not powers of two.
  localparam logic [31:0] NumIRegsU  = 32'(NumIRegs);
  localparam logic [31:0] NumOChansU = 32'(NumOChans);

  if (NumIRegs < 2 || NumOChans < 2 || StackDepth < 1 ||
      OpWidth < OChanW + CmdWidth + DataWidth ||
      OpWidth < AddrWidth + IRegW) begin : g_bad_params
    $error("seq_gen: illegal parameter combination");
  end

  // -------------------------------------------------------------------------
  // Instruction decode
  // -------------------------------------------------------------------------
  seq_gen_op_t           opcode;
  logic [OpWidth-1:0]    operand;
  logic [DataWidth-1:0]  imm;
  logic [CmdWidth-1:0]   cmd;
  logic [OChanW-1:0]     chan;
  logic [AddrWidth-1:0]  addr;
  logic [IRegW-1:0]      reg_idx;
  logic [DataWidth-1:0]  reg_data;
  logic                  reg_bad;
  logic                  chan_bad;
  logic [NumOChans-1:0]  chan_onehot;

  assign opcode   = inst[OpWidth+3:OpWidth];
  assign operand  = inst[OpWidth-1:0];
  assign imm      = operand[DataWidth-1:0];
  assign cmd      = operand[CmdLsb +: CmdWidth];
  assign chan     = operand[ChanLsb +: OChanW];
  assign addr     = operand[AddrLsb +: AddrWidth];
  assign reg_idx  = operand[IRegW-1:0];

  assign reg_bad     = (32'(reg_idx) >= NumIRegsU);
  assign chan_bad    = (32'(chan) >= NumOChansU);
  assign chan_onehot = {{(NumOChans-1){1'b0}}, 1'b1} << chan;

  // Input registers as an array padded to a power of two, so reg_idx can
  // index it directly; padding entries are only reachable on a fault.
  logic [DataWidth-1:0] ireg_arr [2**IRegW];

  for (genvar i = 0; i < 2**IRegW; i++) begin : g_ireg
    if (i < NumIRegs) begin : g_real
      assign ireg_arr[i] = ireg[i*DataWidth +: DataWidth];
    end else begin : g_pad
      assign ireg_arr[i] = '0;
    end
  end

  assign reg_data = ireg_arr[reg_idx];

  // -------------------------------------------------------------------------
  // Return stack
  // -------------------------------------------------------------------------
  logic [AddrWidth-1:0] next_inc;

  assign next_inc = next + AddrWidth'(1);

`ifdef SEQ_GEN_STACK_EN
  logic                 push;
  logic                 pop;
  logic                 stack_full;
  logic                 stack_empty;
  logic [AddrWidth-1:0] stack_top;

  seq_gen_stack #(
    .Depth (StackDepth),
    .Width (AddrWidth)
  ) u_stack (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (next_inc),
    .top       (stack_top),
    .full      (stack_full),
    .empty     (stack_empty)
  );
`endif

  // -------------------------------------------------------------------------
  // Execute: next-state and outputs
  // -------------------------------------------------------------------------
  seq_gen_state_e                state_q;
  seq_gen_state_e                state_d;
  logic [AddrWidth-1:0]          next_d;
  logic [CmdWidth+DataWidth-1:0] oreg_d;
  logic [NumOChans-1:0]          oreg_wen_d;
  logic                          fault;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    next_d     = next;
    oreg_d     = oreg;
    oreg_wen_d = '0;
    fault      = 1'b0;
`ifdef SEQ_GEN_STACK_EN
    push       = 1'b0;
    pop        = 1'b0;
`endif

    // A faulting instruction only raises `fault`; its effects are simply
    // never assigned, so nothing has to be rolled back.
    if (inst_en && state_q == ST_RUN) begin
      case (opcode)
        SEQ_GEN_NO: next_d = next_inc;
        SEQ_GEN_CI: begin
          if (chan_bad) begin
            fault = 1'b1;
          end else begin
            oreg_d     = {cmd, imm};
            oreg_wen_d = chan_onehot;
            next_d     = next_inc;
          end
        end
        SEQ_GEN_CR: begin
          if (chan_bad || reg_bad) begin
            fault = 1'b1;
          end else begin
            oreg_d     = {cmd, reg_data};
            oreg_wen_d = chan_onehot;
            next_d     = next_inc;
          end
        end
        SEQ_GEN_JI: next_d = addr;
        SEQ_GEN_JR: begin
          if (reg_bad) fault  = 1'b1;
          else         next_d = AddrWidth'(reg_data);
        end
        SEQ_GEN_JZ: begin
          if (reg_bad)             fault  = 1'b1;
          else if (reg_data == '0) next_d = addr;
          else                     next_d = next_inc;
        end
        SEQ_GEN_JN: begin
          if (reg_bad)             fault  = 1'b1;
          else if (reg_data != '0) next_d = addr;
          else                     next_d = next_inc;
        end
`ifdef SEQ_GEN_STACK_EN
        SEQ_GEN_CA: begin
          if (stack_full) begin
            fault = 1'b1;
          end else begin
            push   = 1'b1;
            next_d = addr;
          end
        end
        SEQ_GEN_RT: begin
          if (stack_empty) begin
            fault = 1'b1;
          end else begin
            pop    = 1'b1;
            next_d = stack_top;
          end
        end
`endif
        default: fault = 1'b1;
      endcase

      if (fault) begin
        state_d = ST_HALT;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_RUN;
      next     <= '0;
      oreg     <= '0;
      oreg_wen <= '0;
    end else begin
      state_q  <= state_d;
      next     <= next_d;
      oreg     <= oreg_d;
      oreg_wen <= oreg_wen_d;
    end
  end

  assign error = (state_q == ST_HALT);

endmodule

// File: tb/tb_seq_gen.sv
// ---------------------------------------------------------------------------
// tb_seq_gen
//
// Self-checking bench for seq_gen at default parameters. A behavioural
// model (integer program counter, queue-based call stack) predicts every
// output after each clock edge; directed scenarios are followed by a
// randomized instruction stream.
// ---------------------------------------------------------------------------
module tb_seq_gen;

`ifdef SEQ_GEN_STACK_EN
  localparam bit StackEn = 1'b1;
`else
  localparam bit StackEn = 1'b0;
`endif
  localparam int StackDepth = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [19:0] inst;
  logic        inst_en;
  logic [31:0] ireg;
  logic [7:0]  next;
  logic [11:0] oreg;
  logic [7:0]  oreg_wen;
  logic        error;

  always #5 clock = ~clock;

  seq_gen dut (
    .clock    (clock),
    .reset    (reset),
    .inst     (inst),
    .inst_en  (inst_en),
    .ireg     (ireg),
    .next     (next),
    .oreg     (oreg),
    .oreg_wen (oreg_wen),
    .error    (error)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state
  int unsigned m_pc    = 0;
  int unsigned m_oreg  = 0;
  int unsigned m_wen   = 0;
  bit          m_err   = 1'b0;
  int unsigned m_stack [$];

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [19:0] mk(input int op, input int opnd);
    return 20'(((op & 15) << 16) | (opnd & 'hFFFF));
  endfunction

  // Applies one clock edge of the architectural rules to the model.
  task automatic model_step(input bit rst, input bit en, input logic [19:0] i,
                            input logic [31:0] regs);
    int unsigned op, opnd, imm, cmd, chan, addr, rg, rv;
    if (rst) begin
      m_pc = 0; m_oreg = 0; m_wen = 0; m_err = 1'b0;
      m_stack.delete();
      return;
    end
    m_wen = 0;
    if (!en || m_err) return;
    op   = 32'(i) >> 16;
    opnd = 32'(i) & 'hFFFF;
    imm  = opnd & 'hFF;
    cmd  = (opnd >> 8) & 'hF;
    chan = (opnd >> 12) & 'h7;
    addr = (opnd >> 8) & 'hFF;
    rg   = opnd & 'h3;
    rv   = (regs >> (rg * 8)) & 'hFF;
    case (op)
      0: m_pc = (m_pc + 1) % 256;
      1: begin m_oreg = cmd * 256 + imm; m_wen = 1 << chan; m_pc = (m_pc + 1) % 256; end
      2: begin m_oreg = cmd * 256 + rv;  m_wen = 1 << chan; m_pc = (m_pc + 1) % 256; end
      3: m_pc = addr;
      4: m_pc = rv;
      5: m_pc = (rv == 0) ? addr : (m_pc + 1) % 256;
      6: m_pc = (rv != 0) ? addr : (m_pc + 1) % 256;
      7: begin
        if (!StackEn || m_stack.size() >= StackDepth) m_err = 1'b1;
        else begin m_stack.push_back((m_pc + 1) % 256); m_pc = addr; end
      end
      8: begin
        if (!StackEn || m_stack.size() == 0) m_err = 1'b1;
        else m_pc = m_stack.pop_back();
      end
      default: m_err = 1'b1;
    endcase
  endtask

  // Drive one cycle, let the edge happen, then compare all outputs.
  task automatic step(input bit rst, input bit en, input logic [19:0] i,
                      input logic [31:0] regs, input string tag);
    reset   = rst;
    inst_en = en;
    inst    = i;
    ireg    = regs;
    @(posedge clock);
    #1;
    model_step(rst, en, i, regs);
    check({tag, ".next"},     32'(next),     m_pc);
    check({tag, ".oreg"},     32'(oreg),     m_oreg);
    check({tag, ".oreg_wen"}, 32'(oreg_wen), m_wen);
    check({tag, ".error"},    32'(error),    32'(m_err));
  endtask

  initial begin
    reset = 1'b1; inst_en = 1'b0; inst = '0; ireg = '0;

    // Scenario 1: CI and hold
    step(1, 0, mk(0, 0), 0, "rst0");
    check("rst0.plan_next", 32'(next), 32'h0);
    step(0, 1, mk(1, 'h21AA), 0, "ci");
    check("ci.plan_oreg", 32'(oreg), 32'h1AA);
    check("ci.plan_wen",  32'(oreg_wen), 32'h04);
    check("ci.plan_next", 32'(next), 32'h1);
    step(0, 0, mk(0, 0), 0, "idle");

    // Scenario 2: CR, JZ taken/not taken, JN taken
    step(0, 1, mk(2, 'h3202), 32'h00EE_0000, "cr");
    check("cr.plan_oreg", 32'(oreg), 32'h2EE);
    step(0, 1, mk(5, 'h2A03), 32'h0011_2233 & 32'h00FF_FFFF, "jz_taken");
    check("jz_taken.plan_next", 32'(next), 32'h2A);
    step(0, 1, mk(5, 'h4A00), 32'h0000_0011, "jz_not");
    step(0, 1, mk(6, 'hB001), 32'h0000_2200, "jn_taken");
    check("jn_taken.plan_next", 32'(next), 32'hB0);

    // Scenario 3: JR, then a disabled CI
    step(0, 1, mk(4, 'h0001), 32'h0000_7B00, "jr");
    check("jr.plan_next", 32'(next), 32'h7B);
    step(0, 0, mk(1, 'h5155), 0, "ci_dis");

    // Scenario 4: nested calls, returns, underflow
    step(1, 0, mk(0, 0), 0, "rst1");
    step(0, 1, mk(3, 'h1000), 0, "ji10");
    step(0, 1, mk(7, 'h4000), 0, "ca40");
    step(0, 1, mk(7, 'h6000), 0, "ca60");
    step(0, 1, mk(8, 0), 0, "rt1");
    step(0, 1, mk(8, 0), 0, "rt2");
    step(0, 1, mk(8, 0), 0, "rt_under");
    step(0, 1, mk(3, 'h7700), 0, "ji_halted");

    // Scenario 5: overflow
    step(1, 0, mk(0, 0), 0, "rst2");
    step(0, 1, mk(7, 'h2000), 0, "ca20");
    step(0, 1, mk(7, 'h3000), 0, "ca30");
    step(0, 1, mk(7, 'h4000), 0, "ca40b");
    step(0, 1, mk(7, 'h5000), 0, "ca50");
    step(0, 1, mk(7, 'h6000), 0, "ca_over");

    // Scenario 6: illegal opcode, sticky error, reset priority
    step(1, 0, mk(0, 0), 0, "rst3");
    step(0, 1, mk(15, 'h1234), 0, "illegal");
    check("illegal.plan_error", 32'(error), 32'h1);
    step(0, 1, mk(3, 'hEF00), 0, "ji_ignored");
    step(1, 1, mk(3, 'h1200), 0, "rst_wins");
    check("rst_wins.plan_error", 32'(error), 32'h0);
    step(0, 1, mk(3, 'h4800), 0, "ji48");
    check("ji48.plan_next", 32'(next), 32'h48);
    step(0, 1, mk(1, 'h7F01), 0, "ci_ch7");
    step(0, 1, mk(1, 'h0002), 0, "ci_ch0_b2b");

    // Randomized stream
    for (int n = 0; n < 400; n++) begin
      bit          rst, en;
      int          op;
      logic [31:0] regs;
      rst = ($urandom_range(0, 49) == 0) || (m_err && $urandom_range(0, 3) == 0);
      en  = ($urandom_range(0, 9) != 0);
      op  = ($urandom_range(0, 39) == 0) ? int'($urandom_range(9, 15))
                                         : int'($urandom_range(0, 8));
      for (int b = 0; b < 4; b++) begin
        regs[b*8 +: 8] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      end
      step(rst, en, mk(op, int'($urandom)), regs, $sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
